// File: rtl/ex_muldiv_unit_if.sv
// ============================================================================
// Module      : ex_muldiv_unit_if
// Description : Request/result bundle between the EX stage and the
//               multiply/divide engine.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             annul;
    logic             hold;
    logic             stallreq;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             div_zero;

    // EX stage side: issues the instruction, consumes the result
    modport master (
        output op_valid, op, src_a, src_b, annul, hold,
        input  stallreq, busy, done, res_hi, res_lo, div_zero
    );

    // Engine side
    modport slave (
        input  op_valid, op, src_a, src_b, annul, hold,
        output stallreq, busy, done, res_hi, res_lo, div_zero
    );
endinterface

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Multi-cycle MULT/MULTU/DIV/DIVU engine for the EX stage.
//               Shift-add multiplier retiring MUL_BITS bits per cycle and a
//               restoring divider retiring one quotient bit per cycle, both
//               working on magnitudes with a sign fix-up on entry to DONE.
//               WIDTH must be even and >= 8; MUL_BITS (1, 2 or 4) must
//               divide WIDTH.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ex_muldiv_unit_if.slave   bus
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(WIDTH / MUL_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q,    state_d;
    logic [c_cnt_w-1:0]     cnt_q,      cnt_d;
    // Working register: MUL = {partial product, remaining multiplier},
    // DIV = {partial remainder, dividend shifting into quotient}
    logic [2*WIDTH-1:0]     acc_q,      acc_d;
    logic [WIDTH-1:0]       opnd_q,     opnd_d;      // multiplicand / divisor magnitude
    logic                   is_div_q,   is_div_d;
    logic                   neg_lo_q,   neg_lo_d;    // product / quotient sign
    logic                   neg_hi_q,   neg_hi_d;    // remainder sign
    logic [WIDTH-1:0]       res_hi_q,   res_hi_d;
    logic [WIDTH-1:0]       res_lo_q,   res_lo_d;
    logic                   div_zero_q, div_zero_d;

    // Operand conditioning at accept
    logic                   w_is_signed;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic                   w_b_zero;

    assign w_is_signed = ~bus.op[0];
    assign w_a_neg     = w_is_signed & bus.src_a[WIDTH-1];
    assign w_b_neg     = w_is_signed & bus.src_b[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -bus.src_a : bus.src_a;
    assign w_b_mag     = w_b_neg ? -bus.src_b : bus.src_b;
    assign w_b_zero    = (bus.src_b == '0);

    // One multiply step: add multiplicand * low digit into the upper half,
    // then shift the whole register right by one digit
    logic [MUL_BITS-1:0]       w_mul_digit;
    logic [WIDTH+MUL_BITS-1:0] w_mul_pp;
    logic [WIDTH+MUL_BITS-1:0] w_mul_sum;
    logic [2*WIDTH-1:0]        w_mul_next;

    assign w_mul_digit = acc_q[MUL_BITS-1:0];
    assign w_mul_pp    = {{MUL_BITS{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, w_mul_digit};
    assign w_mul_sum   = {{MUL_BITS{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + w_mul_pp;
    assign w_mul_next  = {w_mul_sum, acc_q[WIDTH-1:MUL_BITS]};

    // One restoring divide step: trial-subtract the divisor from the shifted
    // remainder; a borrow in the top bit means restore (quotient bit 0)
    logic [WIDTH:0]         w_div_trial;
    logic [2*WIDTH-1:0]     w_div_next;

    assign w_div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    assign w_div_next  = w_div_trial[WIDTH]
                       ? {acc_q[2*WIDTH-2:0], 1'b0}
                       : {w_div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Final-step values with sign fix-up, used only on the last CALC cycle
    logic [2*WIDTH-1:0]     w_step;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_quo;
    logic [WIDTH-1:0]       w_rem;

    assign w_step = is_div_q ? w_div_next : w_mul_next;
    assign w_prod = neg_lo_q ? -w_step : w_step;
    assign w_quo  = neg_lo_q ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
    assign w_rem  = neg_hi_q ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];

    // Next-state and datapath update; annul beats every transition
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        res_hi_d   = res_hi_q;
        res_lo_d   = res_lo_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.op_valid && !bus.annul) begin
                    div_zero_d = 1'b0;
                    if (bus.op[1] && w_b_zero) begin
                        // Divide by zero completes immediately
                        state_d    = ST_DONE;
                        res_lo_d   = '1;
                        res_hi_d   = bus.src_a;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d  = ST_CALC;
                        cnt_d    = bus.op[1] ? c_div_last : c_mul_last;
                        acc_d    = {{WIDTH{1'b0}}, w_a_mag};
                        opnd_d   = w_b_mag;
                        is_div_d = bus.op[1];
                        neg_lo_d = w_a_neg ^ w_b_neg;
                        neg_hi_d = w_a_neg;
                    end
                end
            end
            ST_CALC: begin
                if (bus.annul) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = w_step;
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                        if (is_div_q) begin
                            res_lo_d = w_quo;
                            res_hi_d = w_rem;
                        end else begin
                            res_lo_d = w_prod[WIDTH-1:0];
                            res_hi_d = w_prod[2*WIDTH-1:WIDTH];
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.annul || !bus.hold) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            res_hi_q   <= res_hi_d;
            res_lo_q   <= res_lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Stall drops in DONE so the pipeline advances on the first !hold cycle
    assign bus.stallreq = bus.op_valid && (state_q != ST_DONE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.res_hi   = res_hi_q;
    assign bus.res_lo   = res_lo_q;
    assign bus.div_zero = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Self-checking bench for ex_muldiv_unit (WIDTH=32) with one
//               MUL_BITS=1 and one MUL_BITS=4 instance and an arithmetic
//               reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;          // 0: MUL_BITS=1 instance, 1: MUL_BITS=4
    logic        ov = 1'b0;
    logic [1:0]  opr = 2'b00;
    logic [31:0] sa = '0;
    logic [31:0] sb = '0;
    logic        annul = 1'b0;
    logic        hold = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.WIDTH(32)) bus1 ();
    ex_muldiv_unit_if #(.WIDTH(32)) bus4 ();

    assign bus1.op_valid = ov & ~sel;
    assign bus4.op_valid = ov & sel;
    assign bus1.op = opr;      assign bus4.op = opr;
    assign bus1.src_a = sa;    assign bus4.src_a = sa;
    assign bus1.src_b = sb;    assign bus4.src_b = sb;
    assign bus1.annul = annul; assign bus4.annul = annul;
    assign bus1.hold = hold;   assign bus4.hold = hold;

    ex_muldiv_unit #(.WIDTH(32), .MUL_BITS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    ex_muldiv_unit #(.WIDTH(32), .MUL_BITS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic        o_stall, o_busy, o_done, o_dz;
    logic [31:0] o_hi, o_lo;
    assign o_stall = sel ? bus4.stallreq : bus1.stallreq;
    assign o_busy  = sel ? bus4.busy     : bus1.busy;
    assign o_done  = sel ? bus4.done     : bus1.done;
    assign o_dz    = sel ? bus4.div_zero : bus1.div_zero;
    assign o_hi    = sel ? bus4.res_hi   : bus1.res_hi;
    assign o_lo    = sel ? bus4.res_lo   : bus1.res_lo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results straight from the arithmetic definition
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint          p;
        longint unsigned pu;
        int              ia, ib;
        dz = 1'b0;
        case (o)
            2'b00: begin p = longint'(signed'(a)) * longint'(signed'(b)); {hi, lo} = p; end
            2'b01: begin pu = {32'b0, a} * {32'b0, b}; {hi, lo} = pu; end
            2'b10: begin
                if (b == 0) begin lo = '1; hi = a; dz = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
                else begin ia = a; ib = b; lo = ia / ib; hi = ia % ib; end
            end
            default: begin
                if (b == 0) begin lo = '1; hi = a; dz = 1'b1; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    // Issue one op (caller is at a negedge), wait for done, check, release
    task automatic run_op(input logic s, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int hold_n);
        logic [31:0] ehi, elo;
        logic        edz;
        int          lat, k;
        logic        stall_ok;
        model(o, a, b, ehi, elo, edz);
        if (o[1] && b == 0)  lat = 1;
        else if (o[1])       lat = 33;
        else                 lat = s ? 9 : 33;
        sel = s; ov = 1'b1; opr = o; sa = a; sb = b; hold = 1'b0;
        #1;
        chk("stall_accept", {31'b0, o_stall}, 32'd1);
        k = 0;
        stall_ok = 1'b1;
        do begin
            @(negedge clk);
            k++;
            if (!o_done && !o_stall) stall_ok = 1'b0;
        end while (!o_done && k < 60);
        chk("latency", k, lat);
        chk("stall_calc", {31'b0, stall_ok}, 32'd1);
        chk("stall_done", {31'b0, o_stall}, 32'd0);
        chk("res_hi", o_hi, ehi);
        chk("res_lo", o_lo, elo);
        chk("div_zero", {31'b0, o_dz}, {31'b0, edz});
        hold = (hold_n > 0);
        for (int i = 1; i <= hold_n; i++) begin
            @(negedge clk);
            chk("done_held", {31'b0, o_done}, 32'd1);
            chk("res_lo_held", o_lo, elo);
            if (i == hold_n) hold = 1'b0;
        end
        @(negedge clk);
        ov = 1'b0;
        chk("idle_busy", {31'b0, o_busy}, 32'd0);
        chk("idle_done", {31'b0, o_done}, 32'd0);
        prev_hi = ehi;
        prev_lo = elo;
    endtask

    initial begin
        logic        seen_done;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_done", {31'b0, o_done}, 32'd0);
        chk("rst_stall", {31'b0, o_stall}, 32'd0);
        chk("rst_hi", o_hi, 32'd0);
        chk("rst_lo", o_lo, 32'd0);
        chk("rst_dz", {31'b0, o_dz}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        run_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        run_op(1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        run_op(1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(1'b0, 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        run_op(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1'b0, 2'b11, 32'h1234_5678, 32'h0000_0000, 0);
        run_op(1'b0, 2'b10, 32'h8765_4321, 32'h0000_0000, 0);

        // Annul in the middle of a MULTU
        sel = 1'b0; ov = 1'b1; opr = 2'b01; sa = 32'hDEAD_BEEF; sb = 32'h0BAD_F00D;
        seen_done = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (o_done) seen_done = 1'b1;
        end
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        chk("annul_busy", {31'b0, o_busy}, 32'd0);
        chk("annul_done", {31'b0, (o_done | seen_done)}, 32'd0);
        chk("annul_hi", o_hi, prev_hi);
        chk("annul_lo", o_lo, prev_lo);
        run_op(1'b0, 2'b00, 32'h0001_2345, 32'hFFFF_FF00, 0);

        // Hold keeps DONE for the extra cycles
        run_op(1'b0, 2'b11, 32'd100, 32'd7, 3);

        // Randomised ops across both instances
        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom_range(3));
            ra = $urandom;
            rb = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(3) == 0) rb = rb >> $urandom_range(31);
            run_op(1'($urandom_range(1)), ro, ra, rb, int'($urandom_range(2)));
        end

        // Reset in the middle of an operation
        sel = 1'b1; ov = 1'b1; opr = 2'b11; sa = 32'd12345; sb = 32'd11;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        ov = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'b0, o_busy}, 32'd0);
        chk("midrst_done", {31'b0, o_done}, 32'd0);
        chk("midrst_stall", {31'b0, o_stall}, 32'd0);
        chk("midrst_hi", o_hi, 32'd0);
        chk("midrst_lo", o_lo, 32'd0);
        chk("midrst_dz", {31'b0, o_dz}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
